clock_div_prog: RTL and testbench
=================================

Name: clock_div_prog

Overview:
Runtime-programmable 50%-duty clock divider driven from the 12 MHz board clock. It is the general successor to the fixed 12→4 MHz and 4 MHz→5 ms dividers. Handles any integer ratio N≥2, odd or even, at exact 50% duty, with glitch-free ratio changes and clean start/stop. A second stage counts output periods to produce a slow toggle clock and a one-cycle strobe. It sits at the top of the clock tree and feeds the ADC sampling and timer logic.

Parameters:
DIV_W, 8, width of divide-ratio field (N range 2..2^DIV_W-1)
DIV_DEFAULT, 3, ratio loaded at reset (12 MHz/3 = 4 MHz)
SLOW_W, 16, width of slow-stage period counter
SLOW_DIV, 20000, clk_out periods per slow_clk half-period (4 MHz → 5 ms half-period)

Ports:
clk_12mhz  in  1  master clock; both edges used
reset  in  1  asynchronous, active-high
enable  in  1  run request; sampled on posedge
div_ratio  in  DIV_W  requested ratio N
div_load  in  1  one-cycle strobe; captures div_ratio
div_ack  out  1  one-cycle pulse when a new ratio takes effect
cfg_err  out  1  one-cycle pulse when div_load carries N<2
running  out  1  high while the divider is producing periods
clk_out  out  1  divided clock, 50% duty
clk_out_n  out  1  ~clk_out
slow_clk  out  1  toggles every SLOW_DIV clk_out periods
slow_clk_n  out  1  ~slow_clk
slow_tick  out  1  one clk_12mhz-cycle pulse on every slow_clk toggle

Behaviour:
- Reset values: cnt=0, active=DIV_DEFAULT, pend_valid=0, clk_out=0, pos_q=0, neg_q=0, running=0, slow_cnt=0, slow_clk=0, slow_clk_n=1, slow_tick=0, div_ack=0, cfg_err=0.
- Reset is asynchronous on the posedge and negedge flops alike. Mid-operation reset drops clk_out to 0 immediately; the resulting runt pulse is accepted.
- Period counter cnt runs 0..active-1 on posedge. The last cycle of a period is cnt==active-1; this is the period boundary.
- Duty shaping:
  - pos_q (posedge) is high for cnt < floor(N/2) for even N, and for cnt < (N-1)/2 for odd N.
  - neg_q (negedge) samples pos_q, only when N is odd; otherwise it is held 0.
  - clk_out = pos_q | neg_q.
  - Result: even N gives N/2 cycles high; odd N gives (N-1)/2 + 0.5 cycles high, i.e. exact 50%.
- Config:
  - div_load with div_ratio≥2 writes pending and sets pend_valid. A later load overwrites pending.
  - div_load with div_ratio<2 pulses cfg_err next cycle; pending and active are untouched.
- Apply rule:
  - While running, pending is copied to active only at a boundary posedge; cnt goes to 0 and div_ack pulses.
  - A div_load arriving in the boundary cycle itself is applied at that boundary.
  - No runt or stretched pulse is permitted at a ratio change.
- Start/stop:
  - enable rising while stopped: running=1 next posedge, cnt starts at 0, clk_out rises on that edge.
  - enable falling: the current period completes, then at the boundary running=0, cnt=0, and clk_out is held low.
  - While stopped, a valid load applies on the next posedge and div_ack pulses.
- Slow stage:
  - slow_cnt increments at each boundary while running.
  - At slow_cnt==SLOW_DIV-1 and a boundary: slow_cnt=0, slow_clk toggles, slow_tick=1 for one cycle.
  - slow_cnt holds while stopped and is cleared only by reset.
- All outputs except clk_out and clk_out_n are registered on posedge.

Decomposition:
- clkdiv_pkg holds DIV_DEFAULT, SLOW_DIV, the minimum-ratio constant MIN_DIV=2, and the ratio type logic[DIV_W-1:0].
- One sub-module, clkdiv_core: counter, boundary detect, odd/even pos/neg shaper. Inputs are active and running; outputs are clk_out and boundary.
- The top level holds config/apply, enable control and the slow stage.

Test Plan:
- Reset, enable=1, N=3 → clk_out period 250 ns, high 125 ns (rising on posedge, falling on negedge); div_ack stays 0.
- Load N=4 mid-period → current 3-cycle period completes, div_ack pulses at the boundary, then period 333.3 ns with 2 cycles high; no runt pulse.
- Load N=1 and N=0 → cfg_err pulses once each; period stays unchanged; div_ack stays 0.
- SLOW_DIV=4, N=3 → slow_clk toggles every 12 clk_12mhz cycles; slow_tick is a single-cycle pulse at each toggle.
- Drop enable mid-period with N=5 → period completes, clk_out stays low, running=0. Re-enable → first rising edge on the next posedge with cnt=0.
- Assert reset mid-high-phase → clk_out, slow_clk, running go 0 asynchronously. After release, N=DIV_DEFAULT (3) again.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants, ratio type and run-state encoding for the programmable clock divider.
package clkdiv_pkg;

  localparam int DIV_W_C       = 8;
  localparam int DIV_DEFAULT_C = 3;
  localparam int SLOW_W_C      = 16;
  localparam int SLOW_DIV_C    = 20000;
  localparam int MIN_DIV       = 2;

  typedef logic [DIV_W_C-1:0] ratio_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/clkdiv_core.sv
// Period counter, boundary detect and odd/even duty shaper.
// A posedge flop sets the high phase; for odd ratios a negedge copy adds the extra half cycle.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_C
) (
  input  logic             clk_12mhz,
  input  logic             reset,
  input  logic [DIV_W-1:0] active,
  input  logic             running,
  input  logic             running_nxt,
  output logic             clk_out,
  output logic             boundary
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] half;
  logic             pos_q;
  logic             neg_q;

  assign half     = active >> 1;
  assign boundary = running && (cnt == active - DIV_W'(1));

  // A start or a boundary always restarts at 0, whose high phase never depends on the new ratio.
  always_comb begin
    cnt_nxt = '0;
    if (running && running_nxt && !boundary) begin
      cnt_nxt = cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      pos_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      pos_q <= running_nxt && (cnt_nxt < half);
    end
  end

  always_ff @(negedge clk_12mhz or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= active[0] & pos_q;
    end
  end

  assign clk_out = pos_q | neg_q;

endmodule

// File: rtl/clock_div_prog.sv
// Programmable 50%-duty divider of the 12 MHz clock: ratio config/apply, start/stop control
// and a slow stage that toggles slow_clk every SLOW_DIV output periods.
module clock_div_prog
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_C,
  parameter int DIV_DEFAULT = DIV_DEFAULT_C,
  parameter int SLOW_W      = SLOW_W_C,
  parameter int SLOW_DIV    = SLOW_DIV_C
) (
  input  logic             clk_12mhz,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             div_ack,
  output logic             cfg_err,
  output logic             running,
  output logic             clk_out,
  output logic             clk_out_n,
  output logic             slow_clk,
  output logic             slow_clk_n,
  output logic             slow_tick
);

  run_state_t        state;
  run_state_t        state_nxt;
  logic [DIV_W-1:0]  active;
  logic [DIV_W-1:0]  pend;
  logic [DIV_W-1:0]  pend_eff;
  logic              pend_valid;
  logic              pend_valid_eff;
  logic              load_ok;
  logic              load_bad;
  logic              apply;
  logic              boundary;
  logic              running_nxt;
  logic [SLOW_W-1:0] slow_cnt;

  assign load_ok  = div_load && (div_ratio >= DIV_W'(MIN_DIV));
  assign load_bad = div_load && !load_ok;

  // A load in the apply cycle itself bypasses the pending register.
  assign pend_eff       = load_ok ? div_ratio : pend;
  assign pend_valid_eff = load_ok || pend_valid;
  assign apply          = pend_valid_eff && (!running || boundary);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_RUN;
      ST_RUN:  if (!enable && boundary) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign running     = (state == ST_RUN);
  assign running_nxt = (state_nxt == ST_RUN);

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      active     <= DIV_W'(DIV_DEFAULT);
      pend       <= '0;
      pend_valid <= 1'b0;
      div_ack    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_ack <= apply;
      cfg_err <= load_bad;
      if (load_ok) begin
        pend <= div_ratio;
      end
      if (apply) begin
        active     <= pend_eff;
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= pend_valid_eff;
      end
    end
  end

  clkdiv_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_12mhz  (clk_12mhz),
    .reset      (reset),
    .active     (active),
    .running    (running),
    .running_nxt(running_nxt),
    .clk_out    (clk_out),
    .boundary   (boundary)
  );

  assign clk_out_n = ~clk_out;

  // boundary is already qualified by running, so slow_cnt holds while stopped.
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      slow_cnt   <= '0;
      slow_clk   <= 1'b0;
      slow_clk_n <= 1'b1;
      slow_tick  <= 1'b0;
    end else begin
      slow_tick <= 1'b0;
      if (boundary) begin
        if (slow_cnt == SLOW_W'(SLOW_DIV - 1)) begin
          slow_cnt   <= '0;
          slow_clk   <= ~slow_clk;
          slow_clk_n <= slow_clk;
          slow_tick  <= 1'b1;
        end else begin
          slow_cnt <= slow_cnt + SLOW_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog: stimulus queues expected periods and pulses,
// a monitor measures clk_out in half-cycles and checks div_ack/cfg_err/slow_tick as they appear.
`timescale 1ns/1ps
module tb_clock_div_prog;
  import clkdiv_pkg::*;

  logic   clk_12mhz = 1'b0;
  logic   reset     = 1'b1;
  logic   enable    = 1'b0;
  logic   div_load  = 1'b0;
  ratio_t div_ratio = '0;
  logic   div_ack, cfg_err, running, clk_out, clk_out_n, slow_clk, slow_clk_n, slow_tick;

  int checks   = 0;
  int failures = 0;

  typedef struct { int hi; int per; } per_t;   // per == 0: period ends in a stop, skip it
  typedef struct { int rise; int val; } evt_t;

  per_t per_q[$];
  evt_t ack_q[$];
  evt_t err_q[$];
  evt_t tick_q[$];

  int   rise_idx = 0;
  logic m_prev = 1'b0;
  bit   m_seen = 1'b0;
  bit   m_rose = 1'b0;
  int   m_h    = 0;
  int   m_hi   = 0;
  logic m_pa = 1'b0, m_pe = 1'b0, m_pt = 1'b0;
  per_t m_p;
  evt_t m_e;

  clock_div_prog #(
    .SLOW_DIV(4)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .reset     (reset),
    .enable    (enable),
    .div_ratio (div_ratio),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .cfg_err   (cfg_err),
    .running   (running),
    .clk_out   (clk_out),
    .clk_out_n (clk_out_n),
    .slow_clk  (slow_clk),
    .slow_clk_n(slow_clk_n),
    .slow_tick (slow_tick)
  );

  always #41.667 clk_12mhz = ~clk_12mhz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_evt(inout evt_t q[$], output evt_t e);
    if (q.size() != 0) e = q.pop_front();
    else e = evt_t'{-1, -1};
  endtask

  task automatic wait_rise_to(input int k);
    int n = 0;
    while (rise_idx < k && n < 400) begin
      @(negedge clk_12mhz);
      n++;
    end
    chk("rise_reached", int'(rise_idx >= k), 1);
  endtask

  // Monitor: samples 1 ns after every clock edge, so lengths are in half-cycles.
  initial begin
    forever begin
      @(posedge clk_12mhz or negedge clk_12mhz);
      #1;
      if (reset) begin
        m_seen = 1'b0; m_h = 0; m_prev = 1'b0; rise_idx = 0;
        m_pa = 1'b0; m_pe = 1'b0; m_pt = 1'b0;
      end else begin
        m_rose = 1'b0;
        if (clk_out && !m_prev) begin
          m_rose = 1'b1;
          rise_idx++;
          chk("clk_out_n", clk_out_n, !clk_out);
          if (m_seen) begin
            chk("period_expected", int'(per_q.size() != 0), 1);
            if (per_q.size() != 0) begin
              m_p = per_q.pop_front();
              chk("high_halves", m_hi, m_p.hi);
              if (m_p.per != 0) chk("period_halves", m_h, m_p.per);
            end
          end
          m_seen = 1'b1;
          m_h = 0;
        end
        if (!clk_out && m_prev) m_hi = m_h;
        m_h++;
        m_prev = clk_out;
        if (clk_12mhz) begin
          if (div_ack) begin
            chk("div_ack_width", m_pa, 0);
            pop_evt(ack_q, m_e);
            chk("div_ack_rise", rise_idx, m_e.rise);
            chk("div_ack_at_period_start", m_rose, 1);
          end
          if (cfg_err) begin
            chk("cfg_err_width", m_pe, 0);
            pop_evt(err_q, m_e);
            chk("cfg_err_rise", rise_idx, m_e.rise);
          end
          if (slow_tick) begin
            chk("slow_tick_width", m_pt, 0);
            pop_evt(tick_q, m_e);
            chk("slow_tick_rise", rise_idx, m_e.rise);
            chk("slow_clk_value", slow_clk, m_e.val);
            chk("slow_clk_n", slow_clk_n, !slow_clk);
          end
          m_pa = div_ack; m_pe = cfg_err; m_pt = slow_tick;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_12mhz);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_clk_out_n", clk_out_n, 1);
    chk("rst_running", running, 0);
    chk("rst_slow_clk", slow_clk, 0);
    chk("rst_slow_clk_n", slow_clk_n, 1);
    chk("rst_slow_tick", slow_tick, 0);
    chk("rst_div_ack", div_ack, 0);
    chk("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    @(negedge clk_12mhz);

    // Default N=3: 3 half-cycles high out of 6; first slow toggle after 4 periods.
    repeat (6) per_q.push_back(per_t'{3, 6});
    tick_q.push_back(evt_t'{5, 1});
    enable = 1'b1;
    @(posedge clk_12mhz); #1;
    chk("start_clk_out", clk_out, 1);
    chk("start_running", running, 1);

    // N=4 loaded mid-period 6; takes effect at period 7.
    wait_rise_to(6);
    ack_q.push_back(evt_t'{7, 0});
    tick_q.push_back(evt_t'{9, 0});
    repeat (4) per_q.push_back(per_t'{4, 8});
    div_ratio = 8'd4; div_load = 1'b1;
    @(negedge clk_12mhz); div_load = 1'b0;

    // Illegal ratios 1 and 0 during period 8.
    wait_rise_to(8);
    err_q.push_back(evt_t'{8, 0});
    err_q.push_back(evt_t'{8, 0});
    div_ratio = 8'd1; div_load = 1'b1;
    @(negedge clk_12mhz); div_load = 1'b0;
    @(negedge clk_12mhz); div_ratio = 8'd0; div_load = 1'b1;
    @(negedge clk_12mhz); div_load = 1'b0;

    // N=5 from period 11, then stop at the end of period 11.
    wait_rise_to(10);
    ack_q.push_back(evt_t'{11, 0});
    per_q.push_back(per_t'{5, 0});
    div_ratio = 8'd5; div_load = 1'b1;
    @(negedge clk_12mhz); div_load = 1'b0;
    wait_rise_to(11);
    enable = 1'b0;
    repeat (8) @(negedge clk_12mhz);
    chk("stopped_running", running, 0);
    chk("stopped_clk_out", clk_out, 0);

    // Restart; slow_cnt held at 3 across the stop, so period 12 ends the slow half-period.
    repeat (2) per_q.push_back(per_t'{5, 10});
    tick_q.push_back(evt_t'{13, 1});
    enable = 1'b1;
    @(posedge clk_12mhz); #1;
    chk("restart_clk_out", clk_out, 1);
    chk("restart_running", running, 1);

    // Reset in the high phase of period 14.
    wait_rise_to(14);
    chk("pre_reset_clk_out", clk_out, 1);
    reset = 1'b1; enable = 1'b0;
    #1;
    chk("areset_clk_out", clk_out, 0);
    chk("areset_slow_clk", slow_clk, 0);
    chk("areset_slow_clk_n", slow_clk_n, 1);
    chk("areset_running", running, 0);
    repeat (2) @(negedge clk_12mhz);
    reset = 1'b0;
    @(negedge clk_12mhz);

    // Ratio back to the default of 3.
    repeat (3) per_q.push_back(per_t'{3, 6});
    enable = 1'b1;
    wait_rise_to(4);
    @(negedge clk_12mhz);

    chk("period_queue_left", per_q.size(), 0);
    chk("ack_queue_left", ack_q.size(), 0);
    chk("err_queue_left", err_q.size(), 0);
    chk("tick_queue_left", tick_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
